konami_vtiming_gen: RTL

//  Parametrised raster timing generator: successor to the fixed 384x264 Konami CRTC. Programmable H/V

---
 rtl/vtg_pkg.sv | 42 ++++
 rtl/vtg_window.sv | 45 ++++
 rtl/konami_vtiming_gen.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/vtg_pkg.sv
// rtl/vtg_pkg.sv - shared timing defaults and types for the raster timing generator
// Purpose: default raster geometry (384x264 Konami CRTC compatible), window selector enum
//          and a bundle of the range/window values used by konami_vtiming_gen.
package vtg_pkg;

  localparam int VTG_H_FIRST = 128;
  localparam int VTG_H_LAST  = 511;
  localparam int VTG_V_FIRST = 248;
  localparam int VTG_V_LAST  = 511;
  localparam int VTG_H_HALF  = 320;
  localparam int VTG_HBL_SET = 128;
  localparam int VTG_HBL_CLR = 256;
  localparam int VTG_HS_SET  = 176;
  localparam int VTG_HS_CLR  = 208;
  localparam int VTG_VBL_SET = 496;
  localparam int VTG_VBL_CLR = 272;
  localparam int VTG_VS_SET  = 248;
  localparam int VTG_VS_CLR  = 256;

  // Index of each window flag inside the generator's flag vector.
  typedef enum logic [1:0] {
    WIN_HBL,
    WIN_HS,
    WIN_VBL,
    WIN_VS
  } win_sel_e;

  // Line/frame end counts plus the eight window edges.
  typedef struct packed {
    int h_last;
    int v_last;
    int hbl_set;
    int hbl_clr;
    int hs_set;
    int hs_clr;
    int vbl_set;
    int vbl_clr;
    int vs_set;
    int vs_clr;
  } vtg_cfg_t;

endpackage

// File: rtl/vtg_window.sv
// rtl/vtg_window.sv - set/reset window flag driven by a counter compare
// Purpose: active-low flag that falls on the step after cnt_i==SET and rises on the step
//          after cnt_i==CLR. CLR is checked first, so SET==CLR never asserts the flag.
// Ports:   clk_i, rst_i (sync active-high), step_i (advance enable),
//          cnt_i [W-1:0] (counter value compared), flag_n_o (window flag, active-low).
module vtg_window #(
  parameter int   W       = 9,
  parameter int   SET     = 0,
  parameter int   CLR     = 0,
  parameter logic RST_VAL = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         step_i,
  input  logic [W-1:0] cnt_i,
  output logic         flag_n_o
);

  localparam logic [W-1:0] SET_V = W'(SET);
  localparam logic [W-1:0] CLR_V = W'(CLR);

  logic flag_q, flag_d;

  always_comb begin
    flag_d = flag_q;
    if (step_i) begin
      if (cnt_i == CLR_V) begin
        flag_d = 1'b1;
      end else if (cnt_i == SET_V) begin
        flag_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flag_q <= RST_VAL;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign flag_n_o = flag_q;

endmodule

// File: rtl/konami_vtiming_gen.sv
// rtl/konami_vtiming_gen.sv - programmable raster timing generator with interlace and flip
// Purpose: H/V raster counters, blank/sync windows, field parity and line/frame strobes.
// Ports:   i_EMU_MCLK master clock; i_MRST sync active-high reset; i_EMU_CLK6MPCEN_n pixel
//          enable (active-low); i_HFLIP/i_VFLIP flip selects; i_INTER interlace request;
//          o_ABS_H/o_ABS_V raw counters; o_FLIP_H/o_FLIP_V flippable counter LSBs;
//          o_HBLANK_n/o_VBLANK_n/o_HSYNC_n/o_VSYNC_n/o_CSYNC_n; o_FRAMEPARITY;
//          o_LINE_STB/o_FRAME_STB wrap strobes.
// Option:  VTG_RASTER_IRQ_EN adds i_IRQ_LINE, i_IRQ_ENA and o_IRQ_n (raster line interrupt).
module konami_vtiming_gen
  import vtg_pkg::*;
#(
  parameter int H_BITS    = 9,
  parameter int V_BITS    = 9,
  parameter int FLIP_BITS = 8,
  parameter int H_FIRST   = VTG_H_FIRST,
  parameter int H_LAST    = VTG_H_LAST,
  parameter int V_FIRST   = VTG_V_FIRST,
  parameter int V_LAST    = VTG_V_LAST,
  parameter int H_HALF    = VTG_H_HALF,
  parameter int HBL_SET   = VTG_HBL_SET,
  parameter int HBL_CLR   = VTG_HBL_CLR,
  parameter int HS_SET    = VTG_HS_SET,
  parameter int HS_CLR    = VTG_HS_CLR,
  parameter int VBL_SET   = VTG_VBL_SET,
  parameter int VBL_CLR   = VTG_VBL_CLR,
  parameter int VS_SET    = VTG_VS_SET,
  parameter int VS_CLR    = VTG_VS_CLR
) (
  input  logic                 i_EMU_MCLK,
  input  logic                 i_MRST,
  input  logic                 i_EMU_CLK6MPCEN_n,
  input  logic                 i_HFLIP,
  input  logic                 i_VFLIP,
  input  logic                 i_INTER,
`ifdef VTG_RASTER_IRQ_EN
  input  logic [V_BITS-1:0]    i_IRQ_LINE,
  input  logic                 i_IRQ_ENA,
  output logic                 o_IRQ_n,
`endif
  output logic [H_BITS-1:0]    o_ABS_H,
  output logic [V_BITS-1:0]    o_ABS_V,
  output logic [FLIP_BITS-1:0] o_FLIP_H,
  output logic [FLIP_BITS-1:0] o_FLIP_V,
  output logic                 o_HBLANK_n,
  output logic                 o_VBLANK_n,
  output logic                 o_HSYNC_n,
  output logic                 o_VSYNC_n,
  output logic                 o_CSYNC_n,
  output logic                 o_FRAMEPARITY,
  output logic                 o_LINE_STB,
  output logic                 o_FRAME_STB
);

  localparam vtg_cfg_t CFG = '{
    h_last: H_LAST, v_last: V_LAST,
    hbl_set: HBL_SET, hbl_clr: HBL_CLR, hs_set: HS_SET, hs_clr: HS_CLR,
    vbl_set: VBL_SET, vbl_clr: VBL_CLR, vs_set: VS_SET, vs_clr: VS_CLR
  };

  localparam logic [H_BITS-1:0] H_FIRST_V = H_BITS'(H_FIRST);
  localparam logic [H_BITS-1:0] H_LAST_V  = H_BITS'(CFG.h_last);
  localparam logic [H_BITS-1:0] H_HALF_V  = H_BITS'(H_HALF);
  localparam logic [V_BITS-1:0] V_FIRST_V = V_BITS'(V_FIRST);
  localparam logic [V_BITS-1:0] V_LAST_V  = V_BITS'(CFG.v_last);

  // The odd field's extra line is V_LAST+1 taken modulo 2**V_BITS, so with
  // V_LAST at the top code the extra line is count 0.
  if (CFG.v_last + 1 > 2**V_BITS) begin : g_bad_v_last
    $error("konami_vtiming_gen: V_LAST+1 exceeds the V counter range");
  end
  if (FLIP_BITS > H_BITS || FLIP_BITS > V_BITS) begin : g_bad_flip
    $error("konami_vtiming_gen: FLIP_BITS wider than a counter");
  end

  logic                pcen;
  logic [H_BITS-1:0]   h_q, h_d;
  logic [V_BITS-1:0]   v_q, v_d, v_last, v_step, vs_cnt;
  logic                parity_q, parity_d, inter_q, inter_d;
  logic                line_stb_q, line_stb_d, frame_stb_q, frame_stb_d;
  logic                odd_field, h_wrap, v_wrap, vbl_step, vs_step;
  logic [3:0]          win_n;

  assign pcen = ~i_EMU_CLK6MPCEN_n;

  always_comb begin
    odd_field   = inter_q & parity_q;
    v_last      = V_LAST_V + V_BITS'(odd_field);
    h_wrap      = (h_q == H_LAST_V);
    v_wrap      = h_wrap && (v_q == v_last);
    // v_step is the V value this pcen would load; V windows compare against it.
    v_step      = v_q;
    if (h_wrap) begin
      v_step = (v_q == v_last) ? V_FIRST_V : v_q + V_BITS'(1);
    end
    h_d         = h_q;
    v_d         = v_q;
    parity_d    = parity_q;
    inter_d     = inter_q;
    line_stb_d  = pcen & h_wrap;
    frame_stb_d = pcen & v_wrap;
    if (pcen) begin
      h_d = h_wrap ? H_FIRST_V : h_q + H_BITS'(1);
      v_d = v_step;
      if (v_wrap) begin
        parity_d = inter_q ? ~parity_q : 1'b0;
        inter_d  = i_INTER;
      end
    end
    // Odd interlaced field: VSYNC edges move half a line later, on the current line.
    vbl_step = pcen & h_wrap;
    vs_step  = pcen & (odd_field ? (h_q == H_HALF_V) : h_wrap);
    vs_cnt   = odd_field ? v_q : v_step;
  end

  always_ff @(posedge i_EMU_MCLK) begin
    if (i_MRST) begin
      h_q         <= H_FIRST_V;
      v_q         <= V_FIRST_V;
      parity_q    <= 1'b0;
      inter_q     <= 1'b0;
      line_stb_q  <= 1'b0;
      frame_stb_q <= 1'b0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      parity_q    <= parity_d;
      inter_q     <= inter_d;
      line_stb_q  <= line_stb_d;
      frame_stb_q <= frame_stb_d;
    end
  end

  vtg_window #(.W(H_BITS), .SET(CFG.hbl_set), .CLR(CFG.hbl_clr), .RST_VAL(1'b0)) u_hbl (
    .clk_i(i_EMU_MCLK), .rst_i(i_MRST), .step_i(pcen), .cnt_i(h_q), .flag_n_o(win_n[WIN_HBL])
  );
  vtg_window #(.W(H_BITS), .SET(CFG.hs_set), .CLR(CFG.hs_clr), .RST_VAL(1'b1)) u_hs (
    .clk_i(i_EMU_MCLK), .rst_i(i_MRST), .step_i(pcen), .cnt_i(h_q), .flag_n_o(win_n[WIN_HS])
  );
  vtg_window #(.W(V_BITS), .SET(CFG.vbl_set), .CLR(CFG.vbl_clr), .RST_VAL(1'b0)) u_vbl (
    .clk_i(i_EMU_MCLK), .rst_i(i_MRST), .step_i(vbl_step), .cnt_i(v_step), .flag_n_o(win_n[WIN_VBL])
  );
  vtg_window #(.W(V_BITS), .SET(CFG.vs_set), .CLR(CFG.vs_clr), .RST_VAL(1'b1)) u_vs (
    .clk_i(i_EMU_MCLK), .rst_i(i_MRST), .step_i(vs_step), .cnt_i(vs_cnt), .flag_n_o(win_n[WIN_VS])
  );

`ifdef VTG_RASTER_IRQ_EN
  logic irq_q, irq_d;

  // Compare against the post-wrap V so the IRQ lands at the end of the line before i_IRQ_LINE.
  always_comb begin
    irq_d = irq_q;
    if (!i_IRQ_ENA) begin
      irq_d = 1'b1;
    end else if (pcen && h_wrap && (v_step == i_IRQ_LINE)) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge i_EMU_MCLK) begin
    if (i_MRST) begin
      irq_q <= 1'b1;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign o_IRQ_n = irq_q;
`endif

  assign o_ABS_H       = h_q;
  assign o_ABS_V       = v_q;
  assign o_FLIP_H      = h_q[FLIP_BITS-1:0] ^ {FLIP_BITS{i_HFLIP}};
  assign o_FLIP_V      = v_q[FLIP_BITS-1:0] ^ {FLIP_BITS{i_VFLIP}};
  assign o_HBLANK_n    = win_n[WIN_HBL];
  assign o_HSYNC_n     = win_n[WIN_HS];
  assign o_VBLANK_n    = win_n[WIN_VBL];
  assign o_VSYNC_n     = win_n[WIN_VS];
  assign o_CSYNC_n     = ~(win_n[WIN_HS] ^ win_n[WIN_VS]);
  assign o_FRAMEPARITY = parity_q;
  assign o_LINE_STB    = line_stb_q;
  assign o_FRAME_STB   = frame_stb_q;

endmodule
